// File: rtl/demux1to4_tdm.sv
// demux1to4_tdm: 1-to-4 time-division demultiplexer.
// It collects four serial slots per frame. Slot 0 is marked by frame_sync.
// A completed frame is presented on A..D together with a one-cycle frame_valid strobe.
// Protocol violations raise a one-cycle frame_err strobe:
//   - a slot that arrives without sync while idle
//   - a sync that arrives while a frame is still being collected
// Optional feature: define DEMUX_FRAME_CNT_EN to add an 8-bit count of completed frames.
module demux1to4_tdm #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic             frame_sync,
    output logic [1:0]       Sel,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] C,
    output logic [WIDTH-1:0] D,
    output logic             frame_valid,
`ifdef DEMUX_FRAME_CNT_EN
    output logic [7:0]       frame_cnt,
`endif
    output logic             frame_err
);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       sel_q, sel_d;
    logic [WIDTH-1:0] shadow0_q, shadow0_d;
    logic [WIDTH-1:0] shadow1_q, shadow1_d;
    logic [WIDTH-1:0] shadow2_q, shadow2_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] c_q, c_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;

    // Next-state logic. Cycles without din_valid hold everything, and both strobes default low.
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        shadow0_d = shadow0_q;
        shadow1_d = shadow1_q;
        shadow2_d = shadow2_q;
        a_d       = a_q;
        b_d       = b_q;
        c_d       = c_q;
        d_d       = d_q;
        valid_d   = 1'b0;
        err_d     = 1'b0;
        if (din_valid) begin
            case (state_q)
                IDLE: begin
                    if (frame_sync) begin
                        shadow0_d = din;
                        sel_d     = 2'd1;
                        state_d   = RUN;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                RUN: begin
                    if (frame_sync) begin
                        // An early sync drops the partial frame and begins a new one.
                        err_d     = 1'b1;
                        shadow0_d = din;
                        sel_d     = 2'd1;
                    end else begin
                        case (sel_q)
                            2'd1: begin
                                shadow1_d = din;
                                sel_d     = 2'd2;
                            end
                            2'd2: begin
                                shadow2_d = din;
                                sel_d     = 2'd3;
                            end
                            2'd3: begin
                                a_d     = shadow0_q;
                                b_d     = shadow1_q;
                                c_d     = shadow2_q;
                                d_d     = din;
                                valid_d = 1'b1;
                                sel_d   = 2'd0;
                                state_d = IDLE;
                            end
                            default: begin
                                // Slot 0 never sits in RUN, so fall back to waiting for a sync.
                                sel_d   = 2'd0;
                                state_d = IDLE;
                            end
                        endcase
                    end
                end
                default: begin
                    sel_d   = 2'd0;
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State, shadow and output registers. Reset clears any partial frame and the last frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            sel_q     <= 2'd0;
            shadow0_q <= '0;
            shadow1_q <= '0;
            shadow2_q <= '0;
            a_q       <= '0;
            b_q       <= '0;
            c_q       <= '0;
            d_q       <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            shadow0_q <= shadow0_d;
            shadow1_q <= shadow1_d;
            shadow2_q <= shadow2_d;
            a_q       <= a_d;
            b_q       <= b_d;
            c_q       <= c_d;
            d_q       <= d_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
        end
    end

`ifdef DEMUX_FRAME_CNT_EN
    logic [7:0] cnt_q, cnt_d;

    // The frame count advances on the same edge that loads A..D, and it wraps naturally at 255.
    always_comb begin
        cnt_d = cnt_q;
        if (valid_d) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // Frame counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign frame_cnt = cnt_q;
`endif

    assign Sel         = sel_q;
    assign A           = a_q;
    assign B           = b_q;
    assign C           = c_q;
    assign D           = d_q;
    assign frame_valid = valid_q;
    assign frame_err   = err_q;

endmodule

// File: tb/tb_demux1to4_tdm.sv
// tb_demux1to4_tdm: self-checking bench for demux1to4_tdm.
// The reference model keeps the partially collected frame as a queue of slots.
module tb_demux1to4_tdm;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] din;
    logic         din_valid;
    logic         frame_sync;
    logic [1:0]   Sel;
    logic [W-1:0] A, B, C, D;
    logic         frame_valid;
    logic         frame_err;
`ifdef DEMUX_FRAME_CNT_EN
    logic [7:0]   frame_cnt;
`endif

    int testCount = 0;
    int failCount = 0;

    // Reference model state.
    logic [W-1:0] partial[$];
    logic [W-1:0] expA, expB, expC, expD;
    logic         expValid, expErr;
    int           expCnt;

    demux1to4_tdm #(.WIDTH(W)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .din(din),
        .din_valid(din_valid),
        .frame_sync(frame_sync),
        .Sel(Sel),
        .A(A),
        .B(B),
        .C(C),
        .D(D),
        .frame_valid(frame_valid),
`ifdef DEMUX_FRAME_CNT_EN
        .frame_cnt(frame_cnt),
`endif
        .frame_err(frame_err)
    );

    // Free-running clock with a 10-time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelReset();
        partial.delete();
        expA = '0; expB = '0; expC = '0; expD = '0;
        expValid = 1'b0;
        expErr = 1'b0;
        expCnt = 0;
    endtask

    // Advance the model by one rising edge.
    task automatic modelEdge(input logic v, input logic s, input logic [W-1:0] d);
        expValid = 1'b0;
        expErr = 1'b0;
        if (v) begin
            if (s) begin
                if (partial.size() != 0) expErr = 1'b1;
                partial.delete();
                partial.push_back(d);
            end else if (partial.size() == 0) begin
                expErr = 1'b1;
            end else begin
                partial.push_back(d);
                if (partial.size() == 4) begin
                    expA = partial[0]; expB = partial[1]; expC = partial[2]; expD = partial[3];
                    expValid = 1'b1;
                    expCnt = (expCnt + 1) % 256;
                    partial.delete();
                end
            end
        end
    endtask

    task automatic checkAll();
        checkOutput("Sel", 32'(Sel), 32'(partial.size()));
        checkOutput("A", 32'(A), 32'(expA));
        checkOutput("B", 32'(B), 32'(expB));
        checkOutput("C", 32'(C), 32'(expC));
        checkOutput("D", 32'(D), 32'(expD));
        checkOutput("frame_valid", 32'(frame_valid), 32'(expValid));
        checkOutput("frame_err", 32'(frame_err), 32'(expErr));
`ifdef DEMUX_FRAME_CNT_EN
        checkOutput("frame_cnt", 32'(frame_cnt), 32'(expCnt));
`endif
    endtask

    // Drive one cycle of inputs, clock it, then compare the outputs against the model.
    task automatic applyStimulus(input logic v, input logic s, input logic [W-1:0] d);
        @(negedge clk);
        din_valid = v;
        frame_sync = s;
        din = d;
        @(posedge clk);
        modelEdge(v, s, d);
        #1;
        checkAll();
    endtask

    task automatic sendFrame(input logic [W-1:0] s0, s1, s2, s3, input int maxGap);
        logic [W-1:0] slots[4];
        slots = '{s0, s1, s2, s3};
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, (i == 0), slots[i]);
            if (i < 3) begin
                int gap;
                gap = (maxGap > 0) ? int'($urandom_range(0, maxGap)) : 0;
                for (int g = 0; g < gap; g++) applyStimulus(1'b0, 1'($urandom_range(0, 1)), W'($urandom));
            end
        end
    endtask

    task automatic applyReset();
        @(negedge clk);
        rst_n = 1'b0;
        din_valid = 1'b0;
        frame_sync = 1'b0;
        #1;
        modelReset();
        checkAll();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        din = '0;
        din_valid = 1'b0;
        frame_sync = 1'b0;
        modelReset();
        #12;
        checkAll();
        @(negedge clk);
        rst_n = 1'b1;

        // Directed frame 1,0,1,1 with continuous valid.
        sendFrame(4'd1, 4'd0, 4'd1, 4'd1, 0);
        checkOutput("dirA", 32'(A), 32'd1);
        checkOutput("dirB", 32'(B), 32'd0);
        checkOutput("dirC", 32'(C), 32'd1);
        checkOutput("dirD", 32'(D), 32'd1);
        checkOutput("dirValid", 32'(frame_valid), 32'd1);
        checkOutput("dirSel", 32'(Sel), 32'd0);

        // All 16 bit patterns as back-to-back frames.
        for (int p = 0; p < 16; p++) begin
            sendFrame(W'(p[3]), W'(p[2]), W'(p[1]), W'(p[0]), 0);
            checkOutput("patValid", 32'(frame_valid), 32'd1);
            checkOutput("patABCD", 32'({A[0], B[0], C[0], D[0]}), 32'(p));
        end

        // The same frame with idle gaps between slots.
        for (int r = 0; r < 4; r++) sendFrame(4'd1, 4'd0, 4'd1, 4'd1, 3);

        // Early sync after two slots, followed by a clean all-zero frame.
        applyStimulus(1'b1, 1'b1, 4'd1);
        applyStimulus(1'b1, 1'b0, 4'd1);
        applyStimulus(1'b1, 1'b1, 4'd0);
        checkOutput("earlyErr", 32'(frame_err), 32'd1);
        checkOutput("earlyHoldA", 32'(A), 32'd1);
        applyStimulus(1'b1, 1'b0, 4'd0);
        applyStimulus(1'b1, 1'b0, 4'd0);
        applyStimulus(1'b1, 1'b0, 4'd0);
        checkOutput("earlyNextA", 32'(A), 32'd0);

        // A slot without sync while idle is dropped.
        applyStimulus(1'b1, 1'b0, 4'd1);
        checkOutput("idleErr", 32'(frame_err), 32'd1);
        checkOutput("idleSel", 32'(Sel), 32'd0);

        // Asynchronous reset between slots 2 and 3 after a non-zero frame.
        sendFrame(4'hF, 4'hE, 4'hD, 4'hC, 0);
        applyStimulus(1'b1, 1'b1, 4'd5);
        applyStimulus(1'b1, 1'b0, 4'd6);
        #2;
        rst_n = 1'b0;
        #1;
        modelReset();
        checkAll();
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b1, 1'b0, 4'd7);
        checkOutput("rstNoValid", 32'(frame_valid), 32'd0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 3) == 0), W'($urandom));
        end

`ifdef DEMUX_FRAME_CNT_EN
        // 257 good frames plus one error leave the counter at 1 after wrapping.
        applyReset();
        for (int f = 0; f < 257; f++) sendFrame(W'($urandom), W'($urandom), W'($urandom), W'($urandom), 0);
        applyStimulus(1'b1, 1'b0, 4'd3);
        checkOutput("cntWrap", 32'(frame_cnt), 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
